snell_refract: RTL and testbench
================================

SNELL_REFRACT -- requirements
Module: snell_refract

Interface
REQ-001 SHALL have port clk, input, 1 bit: single clock; all state updates on its rising edge.
REQ-002 SHALL have port rst, input, 1 bit: synchronous, active-high reset.
REQ-003 SHALL have port in_valid, input, 1 bit: upstream operand set is valid.
REQ-004 SHALL have port in_ready, output, 1 bit: block can accept an operand set.
REQ-005 SHALL have port sin_i, input, 9 bits: sine of incidence angle from the upstream sine stage, unsigned Q1.8 (256 = 1.0).
REQ-006 SHALL have port n1, input, 8 bits: incident-medium refractive index, unsigned Q2.6 (64 = 1.0).
REQ-007 SHALL have port n2, input, 8 bits: refracted-medium refractive index, unsigned Q2.6.
REQ-008 SHALL have port out_valid, output, 1 bit: result valid.
REQ-009 SHALL have port out_ready, input, 1 bit: downstream accepts result.
REQ-010 SHALL have port sin_r, output, 9 bits: sine of refraction angle, unsigned Q1.8.
REQ-011 SHALL have port tir, output, 1 bit: total internal reflection flag.
REQ-012 SHALL have port err, output, 1 bit: invalid operand flag (n2 = 0).

Function
REQ-013 SHALL accept an operand set on a rising edge where in_valid and in_ready are both 1; sin_i, n1, n2 captured on that edge.
REQ-014 SHALL clamp a captured sin_i above 256 to 256.
REQ-015 SHALL assert in_ready only in state IDLE.
REQ-016 SHALL implement states IDLE, MUL, CHK, DIV, DONE; IDLE->MUL on accept; MUL->CHK; CHK->DONE if err or tir, else CHK->DIV; DIV->DONE after exactly 9 iterations; DONE->IDLE on out_valid and out_ready both 1.
REQ-017 SHALL in MUL register P = n1 * sin_i as a 17-bit unsigned product.
REQ-018 SHALL in CHK set err = 1 if n2 = 0; else set tir = 1 if P >= 257 * n2 (i.e. quotient > 256); err has priority over tir.
REQ-019 SHALL in DIV compute sin_r = floor(P / n2) by 9-iteration restoring shift-subtract division, one quotient bit per cycle, MSB first; result range 0..256.
REQ-020 SHALL drive sin_r = 0 when tir or err is 1.
REQ-021 SHALL assert out_valid exactly in DONE; normal-path out_valid rises on the 12th rising edge after the accept edge; tir/err path on the 3rd.
REQ-022 SHALL hold sin_r, tir, err stable while out_valid = 1 and out_ready = 0, for any number of cycles.
REQ-023 SHALL not accept a new operand set in the same cycle the result is consumed (back-to-back throughput: one result per 13 cycles normal path).
REQ-024 SHALL clear tir and err at each accept edge.
REQ-025 SHALL ignore in_valid and input changes in every state except IDLE.

Reset
REQ-026 SHALL on any rising edge with rst = 1 enter IDLE and drive in_ready = 1, out_valid = 0, sin_r = 0, tir = 0, err = 0; all datapath registers cleared.
REQ-027 SHALL let rst abort an operation in any state (including mid-DIV or DONE with out_valid = 1) with no result ever emitted for it.
REQ-028 SHALL give rst priority over a simultaneous accept or result handshake.

Verification
REQ-029 Identity: n1 = 64, n2 = 64, sin_i = 128, out_ready = 1 -> sin_r = 128, tir = 0, err = 0, out_valid on 12th edge after accept.
REQ-030 Air to glass: n1 = 64, n2 = 96, sin_i = 256 -> sin_r = 170, tir = 0.
REQ-031 TIR boundary: n1 = 96, n2 = 64, sin_i = 171 -> sin_r = 256, tir = 0; sin_i = 172 -> tir = 1, sin_r = 0, out_valid on 3rd edge; sin_i = 300 -> clamped to 256, tir = 1.
REQ-032 Error: n2 = 0, n1 = 64, sin_i = 100 -> err = 1, tir = 0, sin_r = 0 on 3rd edge.
REQ-033 Backpressure: out_ready = 0 for 20 cycles after out_valid -> outputs stable, in_ready = 0 throughout; out_ready = 1 -> one handshake, in_ready = 1 next cycle.
REQ-034 Reset mid-DIV: rst = 1 for one cycle 6 edges after accept -> next cycle in_ready = 1, out_valid = 0, all outputs 0; following operand set (n1 = 64, n2 = 64, sin_i = 200) yields sin_r = 200.

Source files
------------

// File: rtl/snell_refract.sv
// snell_refract -- refraction stage of an optical ray pipeline.
// Computes sin_r = floor(n1 * sin_i / n2) (Snell's law) with a bit-serial
// restoring divider and flags total internal reflection or a zero n2.
//
// Ports
//   clk       : clock, all state changes on its rising edge
//   rst       : synchronous, active-high reset
//   in_valid  : upstream operand set valid
//   in_ready  : block idle and able to accept an operand set
//   sin_i     : sine of incidence angle, unsigned Q1.8 (256 = 1.0)
//   n1, n2    : incident / refracted refractive index, unsigned Q2.6
//   out_valid : result valid (held until out_ready)
//   out_ready : downstream accepts the result
//   sin_r     : sine of refraction angle, unsigned Q1.8
//   tir       : total internal reflection (quotient would exceed 1.0)
//   err       : invalid operand (n2 = 0)
module snell_refract (
  input  logic       clk,
  input  logic       rst,
  input  logic       in_valid,
  output logic       in_ready,
  input  logic [8:0] sin_i,
  input  logic [7:0] n1,
  input  logic [7:0] n2,
  output logic       out_valid,
  input  logic       out_ready,
  output logic [8:0] sin_r,
  output logic       tir,
  output logic       err
);

  typedef enum logic [2:0] {
    IDLE = 3'd0,
    MUL  = 3'd1,
    CHK  = 3'd2,
    DIV  = 3'd3,
    DONE = 3'd4
  } state_t;

  state_t      state, state_next;

  logic [8:0]  sin_c;      // clamped incidence sine
  logic [7:0]  n1_q;
  logic [7:0]  n2_q;
  logic [16:0] prod;       // n1 * sin_i, Q3.14
  logic [7:0]  rem;        // partial remainder, always < n2
  logic [8:0]  dvd;        // dividend bits still to be shifted in, MSB first
  logic [8:0]  quo;
  logic [3:0]  cnt;
  logic [8:0]  sin_r_q;
  logic        tir_q;
  logic        err_q;

  logic [8:0]  trial;
  logic        trial_ge;
  logic [16:0] tir_thresh;
  logic        accept;

  assign accept = (state == IDLE) && in_valid;

  // Divider trial subtraction and TIR threshold (257 * n2 <=> quotient > 256)
  always_comb begin
    trial      = {rem, dvd[8]};
    trial_ge   = (trial >= {1'b0, n2_q});
    tir_thresh = 17'(n2_q) * 17'd257;
  end

  // State register
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  // Next-state logic
  always_comb begin
    state_next = state;
    case (state)
      IDLE: begin
        if (in_valid) state_next = MUL;
        else          state_next = IDLE;
      end
      MUL:  state_next = CHK;
      CHK: begin
        if ((n2_q == 8'd0) || (prod >= tir_thresh)) state_next = DONE;
        else                                         state_next = DIV;
      end
      DIV: begin
        // cnt counts completed quotient bits; the 9th bit lands on cnt == 8
        if (cnt == 4'd8) state_next = DONE;
        else             state_next = DIV;
      end
      DONE: begin
        if (out_ready) state_next = IDLE;
        else           state_next = DONE;
      end
      default: state_next = IDLE;
    endcase
  end

  // Handshake outputs decoded from the state register
  always_comb begin
    in_ready  = (state == IDLE);
    out_valid = (state == DONE);
  end

  // Datapath: operand capture, product, check, serial division
  always_ff @(posedge clk) begin
    if (rst) begin
      sin_c   <= 9'd0;
      n1_q    <= 8'd0;
      n2_q    <= 8'd0;
      prod    <= 17'd0;
      rem     <= 8'd0;
      dvd     <= 9'd0;
      quo     <= 9'd0;
      cnt     <= 4'd0;
      sin_r_q <= 9'd0;
      tir_q   <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (accept) begin
            sin_c   <= (sin_i > 9'd256) ? 9'd256 : sin_i;
            n1_q    <= n1;
            n2_q    <= n2;
            tir_q   <= 1'b0;
            err_q   <= 1'b0;
            sin_r_q <= 9'd0;
          end
        end
        MUL: begin
          prod <= 17'(n1_q) * 17'(sin_c);
        end
        CHK: begin
          if (n2_q == 8'd0) begin
            err_q   <= 1'b1;
            sin_r_q <= 9'd0;
          end else if (prod >= tir_thresh) begin
            tir_q   <= 1'b1;
            sin_r_q <= 9'd0;
          end else begin
            // prod < 257*n2 guarantees prod[16:9] < n2, so 9 quotient bits suffice
            rem <= prod[16:9];
            dvd <= prod[8:0];
            quo <= 9'd0;
            cnt <= 4'd0;
          end
        end
        DIV: begin
          if (trial_ge) rem <= 8'(trial - {1'b0, n2_q});
          else          rem <= trial[7:0];
          dvd <= {dvd[7:0], 1'b0};
          quo <= {quo[7:0], trial_ge};
          cnt <= cnt + 4'd1;
          if (cnt == 4'd8) sin_r_q <= {quo[7:0], trial_ge};
        end
        DONE: begin
          // results held until the downstream handshake
        end
        default: begin
          sin_r_q <= 9'd0;
        end
      endcase
    end
  end

  assign sin_r = sin_r_q;
  assign tir   = tir_q;
  assign err   = err_q;

endmodule

// File: tb/tb_snell_refract.sv
// Self-checking bench for snell_refract: expected results are pushed to a
// scoreboard queue at each accept and popped when the DUT presents a result.
module tb_snell_refract;

  logic       clk;
  logic       rst;
  logic       in_valid;
  logic       in_ready;
  logic [8:0] sin_i;
  logic [7:0] n1;
  logic [7:0] n2;
  logic       out_valid;
  logic       out_ready;
  logic [8:0] sin_r;
  logic       tir;
  logic       err;

  int n_tests = 0;
  int n_fail  = 0;

  typedef struct {
    int sin_r;
    int tir;
    int err;
    int lat;
  } exp_t;

  exp_t sb[$];

  snell_refract dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .sin_i     (sin_i),
    .n1        (n1),
    .n2        (n2),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .sin_r     (sin_r),
    .tir       (tir),
    .err       (err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input int obs, input int exp);
    n_tests++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
    end
  endtask

  // Reference model of the refraction result
  function automatic exp_t model(input int a_n1, input int a_n2, input int a_sin);
    exp_t e;
    int s, p;
    s = (a_sin > 256) ? 256 : a_sin;
    p = a_n1 * s;
    e.sin_r = 0; e.tir = 0; e.err = 0;
    if (a_n2 == 0) begin
      e.err = 1; e.lat = 3;
    end else if (p / a_n2 > 256) begin
      e.tir = 1; e.lat = 3;
    end else begin
      e.sin_r = p / a_n2; e.lat = 12;
    end
    return e;
  endfunction

  // Drive an operand set, wait for the result, hold it hold_cyc cycles, consume it
  task automatic run_op(input int a_n1, input int a_n2, input int a_sin, input int hold_cyc);
    exp_t e;
    int edges;
    int hs, ht, he;
    @(negedge clk);
    check("in_ready_idle", int'(in_ready), 1);
    in_valid = 1'b1;
    n1 = 8'(a_n1); n2 = 8'(a_n2); sin_i = 9'(a_sin);
    out_ready = 1'b0;
    sb.push_back(model(a_n1, a_n2, a_sin));
    @(posedge clk);
    edges = 1;
    #1;
    // garbage on the inputs while busy must be ignored
    n1 = 8'($urandom); n2 = 8'($urandom); sin_i = 9'($urandom);
    while (edges < 40) begin
      @(negedge clk);
      if (out_valid) break;
      check("busy_in_ready", int'(in_ready), 0);
      @(posedge clk);
      edges++;
    end
    in_valid = 1'b0;
    e = sb.pop_front();
    check("out_valid_seen", int'(out_valid), 1);
    check("latency", edges, e.lat);
    hs = int'(sin_r); ht = int'(tir); he = int'(err);
    for (int i = 0; i < hold_cyc; i++) begin
      @(negedge clk);
      if ((sin_r !== 9'(hs)) || (tir !== ht[0]) || (err !== he[0]) || !out_valid || in_ready) begin
        check("hold_stable", 0, 1);
      end
    end
    if (hold_cyc > 0) check("hold_in_ready", int'(in_ready), 0);
    check("sin_r", int'(sin_r), e.sin_r);
    check("tir", int'(tir), e.tir);
    check("err", int'(err), e.err);
    out_ready = 1'b1;
    @(posedge clk);
    @(negedge clk);
    out_ready = 1'b0;
    check("post_hs_in_ready", int'(in_ready), 1);
    check("post_hs_out_valid", int'(out_valid), 0);
  endtask

  initial begin
    rst = 1'b1; in_valid = 1'b0; out_ready = 1'b0;
    sin_i = 9'd0; n1 = 8'd0; n2 = 8'd0;
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    check("rst_in_ready", int'(in_ready), 1);
    check("rst_out_valid", int'(out_valid), 0);
    check("rst_sin_r", int'(sin_r), 0);
    check("rst_tir", int'(tir), 0);
    check("rst_err", int'(err), 0);

    run_op(64, 64, 128, 0);   // identity
    run_op(64, 96, 256, 0);   // air to glass -> 170
    run_op(96, 64, 171, 0);   // TIR boundary -> 256
    run_op(96, 64, 172, 0);   // TIR
    run_op(96, 64, 300, 0);   // clamped, TIR
    run_op(64, 0, 100, 0);    // n2 = 0
    run_op(64, 96, 200, 20);  // backpressure
    for (int k = 0; k < 6; k++) begin
      run_op(int'($urandom_range(0, 255)), int'($urandom_range(0, 255)),
             int'($urandom_range(0, 511)), int'($urandom_range(0, 3)));
    end

    // Reset in the middle of DIV: no result may appear for the aborted set
    @(negedge clk);
    in_valid = 1'b1; n1 = 8'd64; n2 = 8'd64; sin_i = 9'd100;
    @(posedge clk);
    #1 in_valid = 1'b0;
    repeat (5) @(posedge clk);
    @(negedge clk);
    rst = 1'b1;
    @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    check("abort_in_ready", int'(in_ready), 1);
    check("abort_out_valid", int'(out_valid), 0);
    check("abort_sin_r", int'(sin_r), 0);
    check("abort_tir", int'(tir), 0);
    check("abort_err", int'(err), 0);
    repeat (15) begin
      @(negedge clk);
      if (out_valid) check("abort_no_result", 1, 0);
    end
    check("abort_sb_empty", sb.size(), 0);
    run_op(64, 64, 200, 0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  // Global watchdog
  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "timeout");
  end

endmodule
